// File: rtl/letter_pkg.sv
// Shared letter codes, FSM state encoding, glyph lengths and valid-code range
// for the letter writer and its glyph ROM.
package letter_pkg;

  // Letter request codes
  localparam logic [2:0] CODE_I = 3'd0;
  localparam logic [2:0] CODE_L = 3'd1;
  localparam logic [2:0] CODE_T = 3'd2;
  localparam logic [2:0] CODE_U = 3'd3;
  localparam logic [2:0] CODE_C = 3'd4;

  // Codes from this value upward carry no glyph
  localparam logic [2:0] CODE_INVALID_MIN = 3'd5;

  // Number of glyph columns per letter
  localparam logic [1:0] LEN_I = 2'd1;
  localparam logic [1:0] LEN_L = 2'd2;
  localparam logic [1:0] LEN_T = 2'd3;
  localparam logic [1:0] LEN_U = 2'd3;
  localparam logic [1:0] LEN_C = 2'd2;

  // Phase of the frame currently on the outputs
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    GLYPH = 2'd2,
    TRAIL = 2'd3
  } state_t;

  function automatic logic code_is_valid(input logic [2:0] code);
    return (code < CODE_INVALID_MIN);
  endfunction

endpackage

// File: rtl/letter_writer_glyph_rom.sv
// Combinational glyph table: (code, column index) -> column bits, glyph
// length and code validity. Out-of-range indices and invalid codes give 000.
module glyph_rom
  import letter_pkg::*;
(
  input  logic [2:0] code,
  input  logic [1:0] index,
  output logic [2:0] column,
  output logic [1:0] length,
  output logic       valid
);

  // Column lookup; bit2 is the top row of the glyph
  always_comb begin
    column = 3'b000;
    length = 2'd0;
    valid  = code_is_valid(code);
    case (code)
      CODE_I: begin
        length = LEN_I;
        if (index == 2'd0) column = 3'b111;
      end
      CODE_L: begin
        length = LEN_L;
        case (index)
          2'd0:    column = 3'b111;
          2'd1:    column = 3'b001;
          default: column = 3'b000;
        endcase
      end
      CODE_T: begin
        length = LEN_T;
        case (index)
          2'd0:    column = 3'b100;
          2'd1:    column = 3'b111;
          2'd2:    column = 3'b100;
          default: column = 3'b000;
        endcase
      end
      CODE_U: begin
        length = LEN_U;
        case (index)
          2'd0:    column = 3'b111;
          2'd1:    column = 3'b001;
          2'd2:    column = 3'b111;
          default: column = 3'b000;
        endcase
      end
      CODE_C: begin
        length = LEN_C;
        case (index)
          2'd0:    column = 3'b111;
          2'd1:    column = 3'b101;
          default: column = 3'b000;
        endcase
      end
      default: begin
        column = 3'b000;
        length = 2'd0;
      end
    endcase
  end

endmodule

// File: rtl/letter_writer.sv
// Letter writer: accepts a letter code over a valid/ready handshake and
// streams one frame of columns (blank lead, glyph columns, blank trail).
// A new request can be taken during the trailing blank so frames abut.
module letter_writer
  import letter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] letter,
  input  logic       letter_valid,
  output logic       letter_ready,
  output logic [2:0] bits,
  output logic       sending,
  output logic       frame_start,
  output logic       err
);

  state_t     state_reg, state_next;
  logic [1:0] index_reg, index_next;
  logic [2:0] code_reg, code_next;
  logic [2:0] bits_reg, bits_next;
  logic       sending_reg, sending_next;
  logic       frame_start_reg, frame_start_next;
  logic       err_reg, err_next;

  logic [2:0] rom_code;
  logic [1:0] rom_index;
  logic [2:0] rom_column;
  logic [1:0] rom_length;
  logic       rom_valid;
  logic       accept;

  assign letter_ready = (state_reg == IDLE) || (state_reg == TRAIL);
  assign accept       = letter_valid && letter_ready;

  // While accepting, the ROM checks the incoming code; otherwise it serves
  // the column that will be shown next for the latched letter.
  assign rom_code  = letter_ready ? letter : code_reg;
  assign rom_index = (state_reg == GLYPH) ? (index_reg + 2'd1) : 2'd0;

  glyph_rom u_glyph_rom (
    .code   (rom_code),
    .index  (rom_index),
    .column (rom_column),
    .length (rom_length),
    .valid  (rom_valid)
  );

  // State, index, latched code and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      index_reg       <= 2'd0;
      code_reg        <= CODE_I;
      bits_reg        <= 3'b000;
      sending_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      index_reg       <= index_next;
      code_reg        <= code_next;
      bits_reg        <= bits_next;
      sending_reg     <= sending_next;
      frame_start_reg <= frame_start_next;
      err_reg         <= err_next;
    end
  end

  // Next-state and next-output decode; outputs default to the idle blank
  always_comb begin
    state_next       = state_reg;
    index_next       = index_reg;
    code_next        = code_reg;
    bits_next        = 3'b000;
    sending_next     = 1'b0;
    frame_start_next = 1'b0;
    err_next         = 1'b0;
    case (state_reg)
      IDLE, TRAIL: begin
        index_next = 2'd0;
        if (accept && rom_valid) begin
          state_next       = LEAD;
          code_next        = letter;
          sending_next     = 1'b1;
          frame_start_next = 1'b1;
        end else begin
          state_next = IDLE;
          err_next   = accept;
        end
      end
      LEAD: begin
        state_next   = GLYPH;
        index_next   = 2'd0;
        bits_next    = rom_column;
        sending_next = 1'b1;
      end
      GLYPH: begin
        sending_next = 1'b1;
        if (({1'b0, index_reg} + 3'd1) < {1'b0, rom_length}) begin
          index_next = index_reg + 2'd1;
          bits_next  = rom_column;
        end else begin
          state_next = TRAIL;
          index_next = 2'd0;
        end
      end
      default: begin
        state_next = IDLE;
        index_next = 2'd0;
      end
    endcase
  end

  assign bits        = bits_reg;
  assign sending     = sending_reg;
  assign frame_start = frame_start_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_letter_writer.sv
// Self-checking bench for letter_writer: a frame-level model predicts every
// output cycle by cycle, and directed scenarios pin the bit streams with
// hand-written literal sequences.
module tb_letter_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_ready;
  logic [2:0] bits;
  logic       sending;
  logic       frame_start;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  letter_writer dut (
    .clk          (clk),
    .reset        (reset),
    .letter       (letter),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .bits         (bits),
    .sending      (sending),
    .frame_start  (frame_start),
    .err          (err)
  );

  // Glyph data as listed for the letters I, L, T, U, C
  localparam logic [2:0] GTAB [0:4][0:2] = '{
    '{3'b111, 3'b000, 3'b000},
    '{3'b111, 3'b001, 3'b000},
    '{3'b100, 3'b111, 3'b100},
    '{3'b111, 3'b001, 3'b111},
    '{3'b111, 3'b101, 3'b000}
  };
  localparam int GLEN [0:4] = '{1, 2, 3, 3, 2};

  typedef struct packed {
    logic [2:0] b;
    logic       s;
    logic       f;
    logic       e;
  } col_t;

  // Model: what is on the outputs now, plus the cycles still owed
  col_t cur_m;
  col_t pend[$];
  logic m_acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      cur_m = '0;
      m_acc = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (letter_valid && pend.size() == 0) begin
        m_acc = 1'b1;
        pend.delete();
        if (letter < 3'd5) begin
          cur_m = '{3'b000, 1'b1, 1'b1, 1'b0};
          for (int i = 0; i < GLEN[letter]; i++)
            pend.push_back('{GTAB[letter][i], 1'b1, 1'b0, 1'b0});
          pend.push_back('{3'b000, 1'b1, 1'b0, 1'b0});
        end else begin
          cur_m = '{3'b000, 1'b0, 1'b0, 1'b1};
        end
      end else if (pend.size() > 0) begin
        cur_m = pend.pop_front();
      end else begin
        cur_m = '0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Captured stream, I-recogniser state and error pulse count
  int   log_q[$];
  int   fb[$];
  int   icount = 0;
  int   errcnt = 0;

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    chk("bits", int'(bits), int'(cur_m.b));
    chk("sending", int'(sending), int'(cur_m.s));
    chk("frame_start", int'(frame_start), int'(cur_m.f));
    chk("err", int'(err), int'(cur_m.e));
    chk("letter_ready", int'(letter_ready), int'(pend.size() == 0));
    if (sending) log_q.push_back(int'(bits));
    if (err) errcnt++;
    if (frame_start) begin
      fb.delete();
      fb.push_back(int'(bits));
    end else if (sending) begin
      fb.push_back(int'(bits));
      if (fb.size() == 3 && fb[0] == 0 && fb[1] == 7 && fb[2] == 0) icount++;
    end
  end

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  // Bounded wait for the model to see the request accepted
  task automatic wait_acc();
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) got = 1'b1;
    end
    if (got) begin
      $display("TXN letter=%0d accepted t=%0t", letter, $time);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1 t=%0t", $time);
    end
  endtask

  task automatic send(input logic [2:0] code);
    letter       = code;
    letter_valid = 1'b1;
    wait_acc();
    nxt();
    letter_valid = 1'b0;
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    chk({name, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      chk(name, log_q[i], exp[i]);
  endtask

  initial begin
    int e[$];
    reset        = 1'b1;
    letter       = 3'd0;
    letter_valid = 1'b0;
    idle(3);
    chk("reset_ready", int'(letter_ready), 1);
    chk("reset_bits", int'(bits), 0);

    // I right after reset release, taken on the first edge
    reset = 1'b0;
    log_q.delete();
    icount = 0;
    send(3'd0);
    idle(5);
    e = '{0, 7, 0};
    check_seq("i_frame", e);
    chk("i_recognised", icount, 1);
    chk("i_ready_after", int'(letter_ready), 1);

    // T then U back to back, U taken during T's trail
    log_q.delete();
    icount = 0;
    send(3'd2);
    send(3'd3);
    idle(6);
    e = '{0, 4, 7, 4, 0, 0, 7, 1, 7, 0};
    check_seq("tu_frames", e);
    chk("tu_not_i", icount, 0);

    // Invalid code 6 in IDLE
    log_q.delete();
    errcnt = 0;
    send(3'd6);
    idle(4);
    chk("invalid_err_pulses", errcnt, 1);
    chk("invalid_no_frame", log_q.size(), 0);

    // Reset in the middle of U, then a clean C
    log_q.delete();
    send(3'd3);
    nxt();
    reset = 1'b1;
    #1;
    chk("abort_bits", int'(bits), 0);
    chk("abort_sending", int'(sending), 0);
    idle(2);
    reset = 1'b0;
    send(3'd4);
    idle(5);
    e = '{0, 7, 0, 7, 5, 0};
    check_seq("abort_then_c", e);

    // L, then I held during L's glyph, switched to C before the trail
    log_q.delete();
    icount = 0;
    send(3'd1);
    letter       = 3'd0;
    letter_valid = 1'b1;
    nxt();
    letter = 3'd4;
    wait_acc();
    nxt();
    letter_valid = 1'b0;
    idle(6);
    e = '{0, 7, 1, 0, 0, 7, 5, 0};
    check_seq("stall_lc", e);
    chk("stall_no_i", icount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/letter_writer.md
LETTER_WRITER -- requirements
Module: letter_writer

Interface
REQ-001 Parameter: none; glyph set and codes are fixed in letter_pkg.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 letter  input  3  letter code: 0=I, 1=L, 2=T, 3=U, 4=C, 5..7 invalid.
REQ-005 letter_valid  input  1  letter holds a request.
REQ-006 letter_ready  output  1  writer accepts a request this cycle.
REQ-007 bits  output  3  column driven to the reader; bit2=top row, bit0=bottom row.
REQ-008 sending  output  1  high on every cycle that belongs to a frame.
REQ-009 frame_start  output  1  high only during the leading-blank cycle of a frame.
REQ-010 err  output  1  one-cycle pulse after an invalid code is accepted.

Function
REQ-011 The writer SHALL count a transfer on a rising edge with letter_valid=1 and letter_ready=1.
REQ-012 Glyph columns SHALL be: I={111}; L={111,001}; T={100,111,100}; U={111,001,111}; C={111,101}.
REQ-013 A frame SHALL be exactly: one 000 column (LEAD), the glyph columns in order (GLYPH), one 000 column (TRAIL); each column lasts one cycle.
REQ-014 The states SHALL be IDLE, LEAD, GLYPH, TRAIL, with a column index of 0..2 used in GLYPH.
REQ-015 bits, sending and frame_start SHALL be registered; a valid transfer at edge k SHALL give LEAD (bits=000, sending=1, frame_start=1) in cycle k+1.
REQ-016 GLYPH SHALL last glyph-length cycles, then TRAIL SHALL follow.
REQ-017 letter_ready SHALL be 1 in IDLE and in TRAIL, and 0 in LEAD and GLYPH.
REQ-018 A valid transfer during TRAIL SHALL move to LEAD of the new letter on the next cycle, with no IDLE gap.
REQ-019 In IDLE: bits=000, sending=0, frame_start=0.
REQ-020 After TRAIL with no transfer, the next state SHALL be IDLE.
REQ-021 An invalid code accepted in IDLE or TRAIL SHALL assert err for the next cycle only, start no frame, and go to IDLE.
REQ-022 letter is sampled only at the accepting edge; changes to letter during a frame SHALL NOT affect that frame.
REQ-023 An I frame SHALL produce exactly 000,111,000, the sequence that i_reader recognises as I.

Reset
REQ-024 While reset is asserted: state=IDLE, index=0, bits=000, sending=0, frame_start=0, err=0, letter_ready=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no further glyph columns.
REQ-026 After reset deasserts, the first transfer SHALL be accepted on the first rising edge.

Structure
REQ-027 letter_pkg SHALL hold the letter-code constants, the state enumeration, the glyph-length constants, and the invalid-code range.
REQ-028 One combinational sub-module, glyph_rom, SHALL map (code, index) to (column, length, valid).
REQ-029 letter_writer SHALL contain the FSM, index counter, output registers and handshake logic.

Verification
REQ-030 Reset, then I at t0 -> bits = 000, 111, 000 on cycles t0+1..t0+3 with sending=1 and frame_start only on t0+1; ready then returns to 1 and state to IDLE.
REQ-031 Back-to-back requests:
- Stimulus: T held valid and accepted, then U presented during T's TRAIL.
- Required bits: 000,100,111,100,000,000,111,001,111,000.
- Required ready: 0 during both LEAD and GLYPH phases.
REQ-032 Invalid code 6 in IDLE -> accepted, err=1 for one cycle, sending stays 0, bits stays 000.
REQ-033 Reset asserted during GLYPH of U (after column 111) -> outputs go to their reset values at once; C requested after release -> clean frame 000,111,101,000.
REQ-034 Handshake stall:
- Stimulus: L accepted, then letter_valid held with code I while L is in GLYPH; letter changes to C two cycles before TRAIL.
- Required: C accepted at TRAIL, the L frame is undisturbed, the sequence is 000,111,001,000,000,111,101,000.
- Loopback: the bits stream drives i_reader with restart=0, and I is high only for an I frame.
